// File: rtl/fdc_decimator.sv
// fdc_decimator
// Boxcar decimator for the FDC frequency code. It adds 2**LOG2_N consecutive
// codes into one full-precision sum and presents each sum on a valid/ready
// output register. A finished sum that cannot be loaded because the register
// still holds an undelivered result is dropped, and the sticky overrun flag is set.
//
// Ports
//   clk, reset    clock; asynchronous active-high reset
//   en            1 = run continuous decimation, 0 = idle (partial block discarded)
//   sample_in     FDC code, taken when sample_valid=1 in ACC
//   sample_valid  single-cycle sample strobe
//   sum_out       latched block sum
//   sum_valid     sum_out holds an undelivered result
//   sum_ready     consumer accepts sum_out when sum_valid & sum_ready
//   overrun       sticky flag, set when a finished block was dropped
//   clr_ovr       synchronous clear of overrun
//   busy          1 while accumulating (ACC state)
//   count         samples accepted so far in the current block
module fdc_decimator #(
    parameter int IN_W   = 5,
    parameter int LOG2_N = 4,
    parameter int OUT_W  = IN_W + LOG2_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [IN_W-1:0]   sample_in,
    input  logic              sample_valid,
    output logic [OUT_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              overrun,
    input  logic              clr_ovr,
    output logic              busy,
    output logic [LOG2_N-1:0] count
);

    typedef enum logic {IDLE, ACC} state_t;

    // N-1 is all ones, so the last sample of a block is count == '1
    localparam logic [LOG2_N-1:0] LAST = '1;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   acc, acc_nxt, final_sum;
    logic [LOG2_N-1:0]  count_nxt;
    logic               blk_done, out_free, load, drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
        end
    end

    assign final_sum = acc + OUT_W'(sample_in);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        blk_done  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = ACC;
                    acc_nxt   = '0;
                    count_nxt = '0;
                end
            end
            ACC: begin
                if (sample_valid && count == LAST) begin
                    // a block ending on the same cycle en falls still completes
                    blk_done  = 1'b1;
                    acc_nxt   = '0;
                    count_nxt = '0;
                    if (!en) state_nxt = IDLE;
                end else if (!en) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    count_nxt = '0;
                end else if (sample_valid) begin
                    acc_nxt   = final_sum;
                    count_nxt = count + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The output register can take a new sum if it is empty or is being
    // drained this very cycle (no bubble between back-to-back results).
    assign out_free = !sum_valid || sum_ready;
    assign load     = blk_done && out_free;
    assign drop     = blk_done && !out_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_out   <= '0;
            sum_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                sum_out   <= final_sum;
                sum_valid <= 1'b1;
            end else if (sum_ready) begin
                sum_valid <= 1'b0;
            end
            // a drop wins over a simultaneous clear
            if (drop)         overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

    assign busy = (state == ACC);

endmodule
